// File: rtl/instr_fetch_server_pkg.sv
// rtl/instr_fetch_server_pkg.sv - shared types and widths for the instruction fetch server
`include "nand_cpu.svh"

package instr_fetch_server_pkg;

    parameter int INSTR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREFETCH,
        DRAIN
    } fetch_srv_state_e;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// rtl/fetch_prefetch_buf.sv - single-entry tag/data buffer with hit compare and invalidate
module fetch_prefetch_buf #(
    parameter int TAG_W  = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              invalidate,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [DATA_W-1:0] buf_data
);

    logic             buf_valid;
    logic [TAG_W-1:0] buf_tag;

    // Invalidate wins over a write landing on the same edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (invalidate) begin
            buf_valid <= 1'b0;
        end else if (wr_en) begin
            buf_valid <= 1'b1;
            buf_tag   <= wr_tag;
            buf_data  <= wr_data;
        end
    end

    assign hit = buf_valid && (buf_tag == lookup_tag);

endmodule

// File: rtl/nand_cpu.svh
// rtl/nand_cpu.svh - CPU-wide width defines
`ifndef NAND_CPU_SVH
`define NAND_CPU_SVH

`define PC_SIZE 16

`endif

// File: rtl/instr_fetch_server.sv
// rtl/instr_fetch_server.sv - instruction fetch responder with one-entry sequential prefetch
`include "nand_cpu.svh"

module instr_fetch_server
    import instr_fetch_server_pkg::*;
#(
    parameter int PC_SIZE     = `PC_SIZE,
    parameter int INSTR_WIDTH = instr_fetch_server_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   fetch_req,
    input  logic [PC_SIZE-1:0]     fetch_pc,
    input  logic                   flush,
    output logic                   fetch_valid,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic                   mem_req,
    output logic [PC_SIZE-1:0]     mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata
);

    localparam logic [PC_SIZE-1:0] PC_ONE = PC_SIZE'(1);

    fetch_srv_state_e       state, state_nx;
    logic                   mem_req_nx;
    logic [PC_SIZE-1:0]     mem_addr_nx;
    logic                   valid_nx;
    logic [INSTR_WIDTH-1:0] instr_nx;
    logic                   buf_wr;
    logic                   buf_hit;
    logic [INSTR_WIDTH-1:0] buf_data;
    logic                   restart;
    logic                   req_live;

    // The request still showing while its valid pulse is out has already been served.
    assign req_live = fetch_req && !fetch_valid;

    fetch_prefetch_buf #(
        .TAG_W  (PC_SIZE),
        .DATA_W (INSTR_WIDTH)
    ) u_buf (
        .clk        (clk),
        .n_rst      (n_rst),
        .invalidate (flush),
        .wr_en      (buf_wr),
        .wr_tag     (mem_addr),
        .wr_data    (mem_rdata),
        .lookup_tag (fetch_pc),
        .hit        (buf_hit),
        .buf_data   (buf_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
        end else begin
            state       <= state_nx;
            mem_req     <= mem_req_nx;
            mem_addr    <= mem_addr_nx;
            fetch_valid <= valid_nx;
            fetch_instr <= instr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        mem_req_nx  = mem_req;
        mem_addr_nx = mem_addr;
        valid_nx    = 1'b0;
        instr_nx    = fetch_instr;
        buf_wr      = 1'b0;
        restart     = 1'b0;

        case (state)
            IDLE: begin
                if (req_live) begin
                    if (buf_hit && !flush) begin
                        valid_nx    = 1'b1;
                        instr_nx    = buf_data;
                        state_nx    = PREFETCH;
                        mem_req_nx  = 1'b1;
                        mem_addr_nx = fetch_pc + PC_ONE;
                    end else begin
                        restart = 1'b1;
                    end
                end
            end
            DEMAND: begin
                if (mem_ack) begin
                    if (flush) begin
                        restart = 1'b1;
                    end else begin
                        valid_nx    = 1'b1;
                        instr_nx    = mem_rdata;
                        buf_wr      = 1'b1;
                        state_nx    = PREFETCH;
                        mem_addr_nx = mem_addr + PC_ONE;
                    end
                end else if (flush) begin
                    state_nx = DRAIN;
                end
            end
            PREFETCH: begin
                if (mem_ack) begin
                    if (flush) begin
                        restart = 1'b1;
                    end else begin
                        buf_wr     = 1'b1;
                        state_nx   = IDLE;
                        mem_req_nx = 1'b0;
                        if (req_live && (fetch_pc == mem_addr)) begin
                            valid_nx = 1'b1;
                            instr_nx = mem_rdata;
                        end
                    end
                end else if (flush || (req_live && (fetch_pc != mem_addr))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase

        // Access finished or abandoned: start a demand for whatever is being asked now.
        if (restart) begin
            if (req_live) begin
                state_nx    = DEMAND;
                mem_req_nx  = 1'b1;
                mem_addr_nx = fetch_pc;
            end else begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_server.sv
// tb/tb_instr_fetch_server.sv - self-checking bench for instr_fetch_server
module tb_instr_fetch_server;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fetch_req;
    logic [15:0] fetch_pc;
    logic        flush;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int lat_min = 1;
    int lat_max = 1;
    int prot_err = 0;

    logic [15:0] mem_img [0:65535];
    logic [15:0] acc_q [$];

    always #5 clk = ~clk;

    instr_fetch_server dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Memory: random latency per access, one outstanding access, records every address.
    initial begin : mem_model
        bit          busy;
        int          cnt;
        logic [15:0] cur;
        busy = 1'b0;
        cnt = 0;
        cur = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (busy) begin
                if (!mem_req) begin
                    busy = 1'b0;
                    if (n_rst) prot_err++;
                end else begin
                    if (mem_addr !== cur) prot_err++;
                    cnt--;
                    if (cnt == 0) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_img[cur];
                        busy = 1'b0;
                    end
                end
            end else if (mem_req === 1'b1) begin
                busy = 1'b1;
                cur = mem_addr;
                cnt = $urandom_range(lat_max, lat_min);
                acc_q.push_back(mem_addr);
            end
        end
    end

    task automatic fetch(input logic [15:0] pc, input bit with_flush,
                         output logic [15:0] data, output int waited, output bit extra);
        data = 16'hxxxx;
        waited = -1;
        extra = 1'b0;
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_pc = pc;
        flush = with_flush;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            flush = 1'b0;
            if (fetch_valid) begin
                data = fetch_instr;
                waited = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(negedge clk);
        extra = fetch_valid;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int n = 0; n < 100 && quiet < 3; n++) begin
            @(negedge clk);
            quiet = mem_req ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            total++; bad++;
            $display("FAIL wait_idle: mem_req=%b after 100 cycles, want 0", mem_req);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        fetch_req = 1'b0;
        fetch_pc = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
        total++; if (fetch_instr !== 16'h0) begin bad++; $display("FAIL reset_instr: got %h want 0000", fetch_instr); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_rst = 1'b1;
    endtask

    task automatic test_first_miss();
        logic [15:0] d; int w; bit x;
        lat_min = 2; lat_max = 2;
        acc_q.delete();
        fetch(16'h0000, 1'b0, d, w, x);
        total++; if (d !== 16'hA5A5) begin bad++; $display("FAIL first_data: got %h want a5a5", d); end
        total++; if (w !== 4) begin bad++; $display("FAIL first_latency: got %0d want 4", w); end
        total++; if (x !== 1'b0) begin bad++; $display("FAIL first_single_pulse: got %b want 0", x); end
        wait_idle();
        total++; if (acc_q.size() != 2 || acc_q[1] !== 16'h0001) begin
            bad++; $display("FAIL first_prefetch: got %0d accesses want 2 with second 0001", acc_q.size());
        end
    endtask

    task automatic test_seq_hit();
        logic [15:0] d; int w; bit x; int n11;
        lat_min = 2; lat_max = 2;
        fetch(16'h0010, 1'b0, d, w, x);
        total++; if (w !== 4) begin bad++; $display("FAIL seq_miss_latency: got %0d want 4", w); end
        wait_idle();
        acc_q.delete();
        fetch(16'h0011, 1'b0, d, w, x);
        total++; if (d !== mem_img[16'h0011]) begin bad++; $display("FAIL seq_hit_data: got %h want %h", d, mem_img[16'h0011]); end
        total++; if (w !== 1) begin bad++; $display("FAIL seq_hit_latency: got %0d want 1", w); end
        wait_idle();
        n11 = 0;
        foreach (acc_q[i]) if (acc_q[i] == 16'h0011) n11++;
        total++; if (n11 != 0) begin bad++; $display("FAIL seq_hit_no_mem: got %0d accesses to 0011 want 0", n11); end
        total++; if (acc_q.size() != 1 || acc_q[0] !== 16'h0012) begin
            bad++; $display("FAIL seq_hit_next_prefetch: got %0d accesses want 1 to 0012", acc_q.size());
        end
    endtask

    task automatic test_drain();
        logic [15:0] d; int w; bit x;
        lat_min = 4; lat_max = 4;
        wait_idle();
        acc_q.delete();
        fetch(16'h0010, 1'b0, d, w, x);
        total++; if (w !== 6) begin bad++; $display("FAIL drain_first_latency: got %0d want 6", w); end
        fetch(16'h0020, 1'b0, d, w, x);
        total++; if (d !== mem_img[16'h0020]) begin bad++; $display("FAIL drain_data: got %h want %h", d, mem_img[16'h0020]); end
        total++; if (w !== 8) begin bad++; $display("FAIL drain_latency: got %0d want 8", w); end
        wait_idle();
        total++; if (acc_q.size() != 4 || acc_q[1] !== 16'h0011 || acc_q[2] !== 16'h0020) begin
            bad++; $display("FAIL drain_sequence: got %0d accesses want 0010 0011 0020 0021", acc_q.size());
        end
    endtask

    task automatic test_flush_demand();
        logic [15:0] d; int w; bit x; int pulses;
        lat_min = 4; lat_max = 4;
        wait_idle();
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_pc = 16'h0030;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin
            bad++; $display("FAIL flush_demand_issue: got req=%b addr=%h want 1 0030", mem_req, mem_addr);
        end
        @(negedge clk);
        flush = 1'b1;
        fetch_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        pulses = 0;
        repeat (12) begin
            if (fetch_valid) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL flush_demand_no_valid: got %0d pulses want 0", pulses); end
        fetch(16'h0021, 1'b0, d, w, x);
        total++; if (w !== 6) begin bad++; $display("FAIL flush_buf_invalid: got latency %0d want 6", w); end
        total++; if (d !== mem_img[16'h0021]) begin bad++; $display("FAIL flush_refetch_data: got %h want %h", d, mem_img[16'h0021]); end
        fetch(16'h0031, 1'b0, d, w, x);
        total++; if (w < 3 || d !== mem_img[16'h0031]) begin
            bad++; $display("FAIL flush_next_miss: got latency %0d data %h want >=3 %h", w, d, mem_img[16'h0031]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d; int w; bit x;
        lat_min = 1; lat_max = 1;
        wait_idle();
        acc_q.delete();
        fetch(16'hFFFF, 1'b0, d, w, x);
        total++; if (w !== 3 || d !== mem_img[16'hFFFF]) begin
            bad++; $display("FAIL wrap_miss: got latency %0d data %h want 3 %h", w, d, mem_img[16'hFFFF]);
        end
        wait_idle();
        total++; if (acc_q.size() != 2 || acc_q[1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_prefetch_addr: got %0d accesses want 2 with second 0000", acc_q.size());
        end
        fetch(16'h0000, 1'b0, d, w, x);
        total++; if (w !== 1 || d !== 16'hA5A5) begin
            bad++; $display("FAIL wrap_hit: got latency %0d data %h want 1 a5a5", w, d);
        end
    endtask

    task automatic test_flush_ack();
        logic [15:0] d; int w; bit x; int pulses; bit seen;
        lat_min = 3; lat_max = 3;
        wait_idle();
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_pc = 16'h0040;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_ack && mem_addr === 16'h0040) begin
                flush = 1'b1;
                fetch_req = 1'b0;
                seen = 1'b1;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL flush_ack_wait: got no ack want ack within 20 cycles"); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_ack_idle: got mem_req=%b want 0", mem_req); end
        pulses = 0;
        repeat (6) begin
            if (fetch_valid) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL flush_ack_no_valid: got %0d pulses want 0", pulses); end
        fetch(16'h0040, 1'b0, d, w, x);
        total++; if (w !== 5 || d !== 16'h1234) begin
            bad++; $display("FAIL flush_ack_not_buffered: got latency %0d data %h want 5 1234", w, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; int w; bit x;
        lat_min = 4; lat_max = 4;
        wait_idle();
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_pc = 16'h0050;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin
            bad++; $display("FAIL async_reset_mem: got req=%b addr=%h want 0 0000", mem_req, mem_addr);
        end
        total++; if (fetch_valid !== 1'b0 || fetch_instr !== 16'h0) begin
            bad++; $display("FAIL async_reset_fetch: got valid=%b instr=%h want 0 0000", fetch_valid, fetch_instr);
        end
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        fetch(16'h0050, 1'b0, d, w, x);
        total++; if (w !== 6 || d !== mem_img[16'h0050]) begin
            bad++; $display("FAIL reset_recover: got latency %0d data %h want 6 %h", w, d, mem_img[16'h0050]);
        end
    endtask

    task automatic test_random();
        logic [15:0] d, pc, prev; int w; bit x, fl; int r;
        lat_min = 1; lat_max = 4;
        prev = 16'h0100;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(9, 0);
            if (r < 5) pc = prev + 16'h1;
            else if (r < 8) pc = 16'($urandom);
            else pc = prev;
            fl = ($urandom_range(4, 0) == 0);
            fetch(pc, fl, d, w, x);
            total++; if (w < 1 || d !== mem_img[pc]) begin
                bad++; $display("FAIL rand_data[%0d]: pc %h got %h latency %0d want %h", i, pc, d, w, mem_img[pc]);
            end
            total++; if (x !== 1'b0) begin bad++; $display("FAIL rand_single_pulse[%0d]: got %b want 0", i, x); end
            if (fl) begin
                total++; if (w < 3) begin bad++; $display("FAIL rand_flush_miss[%0d]: got latency %0d want >=3", i, w); end
            end
            prev = pc;
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_protocol();
        total++; if (prot_err != 0) begin bad++; $display("FAIL mem_protocol: got %0d violations want 0", prot_err); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem_img[a] = 16'($urandom);
        mem_img[16'h0000] = 16'hA5A5;
        mem_img[16'h0040] = 16'h1234;
        test_reset();
        test_first_miss();
        test_seq_hit();
        test_drain();
        test_flush_demand();
        test_wrap();
        test_flush_ack();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_server.md
# instr_fetch_server

Responder side of the instruction-fetch path. It accepts PC requests from the fetch unit, obtains instruction words from a variable-latency instruction memory port, and returns them with a one-cycle valid pulse. It keeps a one-entry sequential prefetch buffer that holds PC+1. It handles redirects (branch override, interrupt entry/return) by flushing the buffer and discarding in-flight data.

## Interface
- `PC_SIZE`, default `` `PC_SIZE `` (16): PC and memory address width.
- `INSTR_WIDTH`, default 16: instruction word width.
- `clk`  in  1  sole clock; everything is rising-edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  demand request. Held with a stable `fetch_pc` until `fetch_valid`.
- `fetch_pc`  in  PC_SIZE  requested PC.
- `flush`  in  1  redirect pulse. Invalidates the buffer and cancels the pending demand.
- `fetch_valid`  out  1  one-cycle pulse: `fetch_instr` holds the word for the current `fetch_pc`.
- `fetch_instr`  out  INSTR_WIDTH  registered instruction word.
- `mem_req`  out  1  memory request. Held until `mem_ack`.
- `mem_addr`  out  PC_SIZE  memory address. Stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle completion. Occurs no earlier than 1 cycle after `mem_req` rises.
- `mem_rdata`  in  INSTR_WIDTH  valid when `mem_ack` is high.

## Operation
- States:
  - IDLE.
  - DEMAND: memory access for a requested PC.
  - PREFETCH: memory access for buffer tag + 1.
  - DRAIN: an outstanding access whose data is discarded.
- Buffer: `buf_valid`, `buf_tag[PC_SIZE]`, `buf_data[INSTR_WIDTH]`.
- IDLE, `fetch_req` high, `buf_valid` high and `fetch_pc == buf_tag` (hit):
  - Next cycle: `fetch_valid` = 1 and `fetch_instr` = `buf_data`.
  - Then launch PREFETCH of `fetch_pc + 1`.
- IDLE, `fetch_req` high, miss: next cycle `mem_req` = 1, `mem_addr` = `fetch_pc`, go to DEMAND.
- DEMAND, on `mem_ack`:
  - Next cycle: `fetch_valid` = 1 and `fetch_instr` = `mem_rdata`.
  - Write `mem_rdata` into the buffer with tag `fetch_pc`.
  - Then launch PREFETCH of `fetch_pc + 1`.
- PREFETCH, on `mem_ack`:
  - Buffer ← (`mem_addr`, `mem_rdata`); go to IDLE.
  - If `fetch_req` is high with `fetch_pc == mem_addr`, also pulse `fetch_valid` with that data next cycle.
- PREFETCH, `fetch_req` with a different `fetch_pc`: go to DRAIN. After the ack, issue DEMAND for the new PC.
- PC + 1 is computed modulo 2^PC_SIZE (all-ones wraps to 0).
- `flush`:
  - Clears `buf_valid` in the same edge.
  - DEMAND or PREFETCH → DRAIN. No `fetch_valid` is produced for the cancelled demand.
  - IDLE: stays IDLE.
- DRAIN: on `mem_ack`, data is discarded. Go to DEMAND if `fetch_req` is high, otherwise IDLE.
- `flush` and `mem_ack` in the same cycle: ack data is discarded and the buffer is not written. Next state is IDLE, or DEMAND if `fetch_req` is high.
- `flush` and `fetch_req` in the same cycle: the request is treated as a miss.
- `flush` has priority over a buffer hit in the same cycle.
- `mem_req` is never dropped before `mem_ack`. At most one memory access is outstanding.

## Timing
- Reset (async assert): state IDLE, `buf_valid` = 0, `fetch_valid` = 0, `fetch_instr` = 0, `mem_req` = 0, `mem_addr` = 0.
- Reset deassertion is synchronised externally. The first request is accepted on the first edge after release.
- Reset asserted mid-access drops the access. The memory side must tolerate `mem_req` falling without an ack.
- Hit latency: request sampled at edge N → `fetch_valid` high after edge N+1.
- Miss latency: `mem_req` rises after edge N+1. `fetch_valid` rises on the edge after `mem_ack`.
- Minimum miss latency is 3 cycles with a 1-cycle memory.
- `fetch_valid` is never high on two consecutive cycles for the same request.

## Structure
- `nand_cpu.svh` supplies `PC_SIZE`.
- Put in the shared package:
  - the state enum `fetch_srv_state_e` (IDLE, DEMAND, PREFETCH, DRAIN);
  - the parameter `INSTR_WIDTH`.
- Sub-module: `fetch_prefetch_buf`, the tag/data register with hit compare and invalidate. It is reused later for a deeper buffer.
- The top module holds the FSM and the memory handshake.

## Test plan
- Reset, then request PC 0x0000 with 2-cycle memory latency (mem_rdata 0xA5A5):
  - `fetch_valid` fires once with 0xA5A5.
  - Then `mem_req` follows with `mem_addr` 0x0001.
- Sequential PCs 0x0010, 0x0011 with prefetch complete before the second request: the 0x0011 request hits, with `fetch_valid` one cycle after it and no `mem_req` for 0x0011.
- Request 0x0020 while the prefetch of 0x0011 is outstanding:
  - DRAIN discards 0x0011 data.
  - Then a demand for 0x0020 is issued and its word is returned.
- `flush` during DEMAND for 0x0030:
  - No `fetch_valid`; the buffer is invalid afterwards.
  - A following request for 0x0031 misses.
- PC 0xFFFF fetched: prefetch address wraps to 0x0000. A request for 0x0000 then hits.
- `flush` coincident with `mem_ack` (rdata 0x1234):
  - 0x1234 is neither delivered nor buffered.
  - Asserting `n_rst` low mid-DEMAND clears all outputs immediately, without waiting for a clock edge.
